gather_route_table_writer: RTL and testbench

Runtime programming engine for the gather route table. Accepts insert/update/delete/clear commands on a valid/ready config port, keeps a shadow copy of the table's stream IDs and valid bits, and drives a single write port into the route-table storage. Sits between the NoC configuration agent and the gather route-table memory. Makes the table reprogrammable without `$readmemb` reloads.

---
 rtl/gather_rt_pkg.sv | 46 ++++
 rtl/gather_route_table_writer.sv | 210 +++++++++++++++++++++
 tb/tb_gather_route_table_writer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gather_rt_pkg.sv
// Shared types and helpers for the gather route-table programming engine.
`ifndef CN
`define CN 4
`endif
`ifndef ROUTE_TABLE_DEPTH
`define ROUTE_TABLE_DEPTH 8
`endif

package gather_rt_pkg;

  localparam int RT_CN = `CN;
  localparam logic [9:0] RT_EMPTY_SID = 10'h3FF;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_CLEAR  = 2'd3
  } rt_op_e;

  typedef enum logic [2:0] {
    ST_OK_NEW       = 3'd0,
    ST_OK_UPDATE    = 3'd1,
    ST_OK_DELETE    = 3'd2,
    ST_OK_CLEAR     = 3'd3,
    ST_OK_NOP       = 3'd4,
    ST_ERR_FULL     = 3'd5,
    ST_ERR_NOTFOUND = 3'd6,
    ST_ERR_BAD      = 3'd7
  } rt_status_e;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SCAN  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4,
    S_RESP  = 3'd5
  } rt_state_e;

  // True when exactly one bit of the VC mask is set.
  function automatic logic rt_is_onehot(input logic [RT_CN-1:0] v);
    return (v != '0) && ((v & (v - RT_CN'(1))) == '0);
  endfunction

endpackage

// File: rtl/gather_route_table_writer.sv
// Runtime programming engine for the gather route table: accepts
// insert/update/delete/clear commands, keeps a shadow of stream IDs and
// valid bits, and drives the single write port of the route-table memory.
module gather_route_table_writer
  import gather_rt_pkg::*;
#(
  parameter int DEPTH = `ROUTE_TABLE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_op,
  input  logic [9:0]          cfg_sid,
  input  logic [`CN-1:0]      cfg_vc,
  output logic                tab_we,
  output logic [AW-1:0]       tab_addr,
  output logic [10+`CN-1:0]   tab_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2:0]          rsp_status,
  output logic [AW-1:0]       rsp_idx,
  output logic                busy
);

  localparam logic [AW-1:0]     LAST  = AW'(DEPTH - 1);
  localparam logic [10+`CN-1:0] EMPTY = {{`CN{1'b0}}, RT_EMPTY_SID};

  rt_state_e          state_q, state_d;
  rt_op_e             op_q, op_d;
  logic [9:0]         sid_q, sid_d;
  logic [`CN-1:0]     vc_q, vc_d;
  logic [AW-1:0]      scan_q, scan_d;
  logic               free_vld_q, free_vld_d;
  logic [AW-1:0]      free_idx_q, free_idx_d;
  logic               hit_q, hit_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [10+`CN-1:0]  wdata_q, wdata_d;
  rt_status_e         status_q, status_d;
  logic [AW-1:0]      ridx_q, ridx_d;

  // Shadow of the table contents; INIT/CLEAR sweeps establish it, so no reset.
  logic [9:0]         tsid_q [DEPTH];
  logic [DEPTH-1:0]   val_q;

  logic               sh_we;
  logic [AW-1:0]      sh_idx;
  logic [9:0]         sh_sid;
  logic               sh_val;
  logic               bad_cmd;
  logic               hit_now;

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tab_we     = (state_q == S_INIT) || (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign tab_addr   = addr_q;
  assign tab_wdata  = wdata_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_status = status_q;
  assign rsp_idx    = ridx_q;

  assign bad_cmd = (cfg_sid == RT_EMPTY_SID) ||
                   ((rt_op_e'(cfg_op) == OP_WRITE) && !rt_is_onehot(cfg_vc));
  assign hit_now = val_q[scan_q] && (tsid_q[scan_q] == sid_q);

  // Next-state and datapath decisions for the command sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sid_d      = sid_q;
    vc_d       = vc_q;
    scan_d     = scan_q;
    free_vld_d = free_vld_q;
    free_idx_d = free_idx_q;
    hit_d      = hit_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    status_d   = status_q;
    ridx_d     = ridx_q;
    sh_we      = 1'b0;
    sh_idx     = addr_q;
    sh_sid     = RT_EMPTY_SID;
    sh_val     = 1'b0;
    unique case (state_q)
      S_INIT, S_CLEAR: begin
        // Sweep: one empty-encoding write per cycle at addr_q.
        sh_we = 1'b1;
        if (addr_q == LAST) begin
          if (state_q == S_CLEAR) begin
            status_d = ST_OK_CLEAR;
            ridx_d   = '0;
            state_d  = S_RESP;
          end else begin
            state_d  = S_IDLE;
          end
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (cfg_valid) begin
          op_d   = rt_op_e'(cfg_op);
          sid_d  = cfg_sid;
          vc_d   = cfg_vc;
          ridx_d = '0;
          unique case (rt_op_e'(cfg_op))
            OP_NOP: begin
              status_d = ST_OK_NOP;
              state_d  = S_RESP;
            end
            OP_CLEAR: begin
              addr_d  = '0;
              wdata_d = EMPTY;
              state_d = S_CLEAR;
            end
            default: begin
              if (bad_cmd) begin
                status_d = ST_ERR_BAD;
                state_d  = S_RESP;
              end else begin
                scan_d     = '0;
                free_vld_d = 1'b0;
                hit_d      = 1'b0;
                state_d    = S_SCAN;
              end
            end
          endcase
        end
      end
      S_SCAN: begin
        if (!val_q[scan_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = scan_q;
        end
        if (hit_now) begin
          hit_d   = 1'b1;
          addr_d  = scan_q;
          wdata_d = (op_q == OP_WRITE) ? {vc_q, sid_q} : EMPTY;
          state_d = S_WRITE;
        end else if (scan_q == LAST) begin
          // Free slot is the lowest empty index seen, including this one.
          if ((op_q == OP_WRITE) && (free_vld_q || !val_q[scan_q])) begin
            addr_d  = free_vld_q ? free_idx_q : scan_q;
            wdata_d = {vc_q, sid_q};
            state_d = S_WRITE;
          end else begin
            status_d = (op_q == OP_WRITE) ? ST_ERR_FULL : ST_ERR_NOTFOUND;
            state_d  = S_RESP;
          end
        end else begin
          scan_d = scan_q + AW'(1);
        end
      end
      S_WRITE: begin
        sh_we  = 1'b1;
        sh_sid = (op_q == OP_WRITE) ? sid_q : RT_EMPTY_SID;
        sh_val = (op_q == OP_WRITE);
        if (op_q == OP_WRITE) status_d = hit_q ? ST_OK_UPDATE : ST_OK_NEW;
        else                  status_d = ST_OK_DELETE;
        ridx_d  = addr_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control and output registers; reset restarts the INIT sweep at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      op_q       <= OP_NOP;
      sid_q      <= RT_EMPTY_SID;
      vc_q       <= '0;
      scan_q     <= '0;
      free_vld_q <= 1'b0;
      free_idx_q <= '0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= EMPTY;
      status_q   <= ST_OK_NEW;
      ridx_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sid_q      <= sid_d;
      vc_q       <= vc_d;
      scan_q     <= scan_d;
      free_vld_q <= free_vld_d;
      free_idx_q <= free_idx_d;
      hit_q      <= hit_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      status_q   <= status_d;
      ridx_q     <= ridx_d;
    end
  end

  // Shadow table update, mirroring every write issued on the table port.
  always_ff @(posedge clk) begin
    if (sh_we) begin
      tsid_q[sh_idx] <= sh_sid;
      val_q[sh_idx]  <= sh_val;
    end
  end

endmodule

// File: tb/tb_gather_route_table_writer.sv
// Directed plus randomized check of gather_route_table_writer against a
// table-level reference model (linear search over sid/valid arrays).
`ifndef CN
`define CN 4
`endif

module tb_gather_route_table_writer;

  localparam int CN    = `CN;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 10 + CN;
  localparam logic [DW-1:0] EMPTY = {{CN{1'b0}}, 10'h3FF};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_op = 2'd0;
  logic [9:0]    cfg_sid = 10'd0;
  logic [CN-1:0] cfg_vc = '0;
  logic          tab_we;
  logic [AW-1:0] tab_addr;
  logic [DW-1:0] tab_wdata;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [2:0]    rsp_status;
  logic [AW-1:0] rsp_idx;
  logic          busy;

  gather_route_table_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_sid(cfg_sid), .cfg_vc(cfg_vc),
    .tab_we(tab_we), .tab_addr(tab_addr), .tab_wdata(tab_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_idx(rsp_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference table
  logic [9:0] m_sid [DEPTH];
  bit         m_val [DEPTH];

  // Expected results for the current command
  int            e_status, e_idx, e_rsp, e_nwr, e_wcyc, e_addr;
  logic [DW-1:0] e_data;

  // Observed results for the current command
  int            o_rsp, o_nwr, o_wcyc, o_addr;
  logic [DW-1:0] o_data;
  bit            o_clear_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 1'b0;
      m_sid[i] = 10'h3FF;
    end
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [9:0] sid, input logic [CN-1:0] vc);
    int hit  = -1;
    int free = -1;
    e_nwr = 0; e_idx = 0; e_wcyc = 0; e_addr = 0; e_data = EMPTY;
    if (op == 2'd0) begin
      e_status = 4; e_rsp = 1;
    end else if (op == 2'd3) begin
      e_status = 3; e_rsp = DEPTH + 1; e_nwr = DEPTH;
      model_clear();
    end else if (sid == 10'h3FF || (op == 2'd1 && $countones(vc) != 1)) begin
      e_status = 7; e_rsp = 1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (m_val[i] && m_sid[i] == sid && hit < 0) hit = i;
        if (!m_val[i] && free < 0) free = i;
      end
      if (hit >= 0) begin
        e_nwr = 1; e_wcyc = hit + 2; e_rsp = hit + 3; e_addr = hit; e_idx = hit;
        if (op == 2'd1) begin
          e_status = 1; e_data = {vc, sid}; m_sid[hit] = sid;
        end else begin
          e_status = 2; m_val[hit] = 1'b0;
        end
      end else if (op == 2'd1 && free >= 0) begin
        e_status = 0; e_nwr = 1; e_wcyc = DEPTH + 1; e_rsp = DEPTH + 2;
        e_addr = free; e_idx = free; e_data = {vc, sid};
        m_val[free] = 1'b1; m_sid[free] = sid;
      end else begin
        e_status = (op == 2'd1) ? 5 : 6;
        e_rsp = DEPTH + 1;
      end
    end
  endtask

  task automatic init_sweep(input string tag);
    bit ok = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      if (!(tab_we === 1'b1 && tab_addr === AW'(c) && tab_wdata === EMPTY &&
            cfg_ready === 1'b0 && rsp_valid === 1'b0 && busy === 1'b1)) ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "_sweep"}, 32'(ok), 32'(1));
    check({tag, "_ready"}, 32'(cfg_ready), 32'(1));
    check({tag, "_norsp"}, 32'(rsp_valid), 32'(0));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'(1));
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [9:0] sid,
                        input logic [CN-1:0] vc, input int stall);
    bit stable;
    logic [2:0] st0;
    logic [AW-1:0] ix0;
    model_cmd(op, sid, vc);
    wait_ready();
    cfg_valid = 1'b1; cfg_op = op; cfg_sid = sid; cfg_vc = vc;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0; cfg_op = 2'd0;
    o_nwr = 0; o_rsp = -1; o_wcyc = -1; o_addr = -1; o_data = '0; o_clear_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (tab_we === 1'b1) begin
        o_nwr++; o_wcyc = c; o_addr = int'(tab_addr); o_data = tab_wdata;
        if (tab_addr !== AW'(c - 1) || tab_wdata !== EMPTY) o_clear_ok = 1'b0;
      end
      if (rsp_valid === 1'b1) begin
        o_rsp = c;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_rsp_cycle"}, 32'(o_rsp), 32'(e_rsp));
    check({tag, "_status"}, 32'(rsp_status), 32'(e_status));
    check({tag, "_idx"}, 32'(rsp_idx), 32'(e_idx));
    check({tag, "_nwrites"}, 32'(o_nwr), 32'(e_nwr));
    if (e_nwr == 1) begin
      check({tag, "_wr_cycle"}, 32'(o_wcyc), 32'(e_wcyc));
      check({tag, "_wr_addr"}, 32'(o_addr), 32'(e_addr));
      check({tag, "_wr_data"}, 32'(o_data), 32'(e_data));
    end
    if (op == 2'd3) check({tag, "_clear_sweep"}, 32'(o_clear_ok), 32'(1));
    if (o_rsp > 0) begin
      stable = 1'b1; st0 = rsp_status; ix0 = rsp_idx;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_status !== st0 || rsp_idx !== ix0 ||
            cfg_ready !== 1'b0 || tab_we !== 1'b0) stable = 1'b0;
      end
      if (stall > 0) check({tag, "_stall_stable"}, 32'(stable), 32'(1));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'(0));
      check({tag, "_ready_after"}, 32'(cfg_ready), 32'(1));
    end
  endtask

  initial begin
    logic [1:0]    r_op;
    logic [9:0]    r_sid;
    logic [CN-1:0] r_vc;
    int            r;

    // Reset values
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_tab_we", 32'(tab_we), 32'(1));
    check("rst_tab_addr", 32'(tab_addr), 32'(0));
    check("rst_tab_wdata", 32'(tab_wdata), 32'(EMPTY));
    check("rst_cfg_ready", 32'(cfg_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_status", 32'(rsp_status), 32'(0));
    check("rst_rsp_idx", 32'(rsp_idx), 32'(0));
    check("rst_busy", 32'(busy), 32'(1));
    rst = 1'b0;
    #1;
    init_sweep("init");

    // Insert, then update the same sid
    do_cmd("wr_new", 2'd1, 10'd5, 4'b0010, 0);
    do_cmd("wr_upd", 2'd1, 10'd5, 4'b1000, 0);

    // Malformed commands and NOP
    do_cmd("bad_vc", 2'd1, 10'd7, 4'b0110, 5);
    do_cmd("bad_sid", 2'd1, 10'h3FF, 4'b0001, 0);
    do_cmd("bad_del", 2'd2, 10'h3FF, 4'b0000, 0);
    do_cmd("nop", 2'd0, 10'd1, 4'b0000, 2);

    // Clear, fill, overflow, missing delete, delete and reuse
    do_cmd("clear", 2'd3, 10'd0, 4'b0000, 0);
    for (int i = 0; i < DEPTH; i++)
      do_cmd("fill", 2'd1, 10'(10 + i), CN'(1) << (i % CN), 0);
    do_cmd("full", 2'd1, 10'd99, 4'b0100, 0);
    do_cmd("notfound", 2'd2, 10'd200, 4'b0000, 0);
    do_cmd("del_hit", 2'd2, 10'd13, 4'b0000, 0);
    do_cmd("reuse", 2'd1, 10'd99, 4'b0100, 0);
    do_cmd("upd_last", 2'd1, 10'd17, 4'b0001, 1);

    // Reset during the scan of a DELETE
    wait_ready();
    cfg_valid = 1'b1; cfg_op = 2'd2; cfg_sid = 10'd16; cfg_vc = '0;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0; cfg_op = 2'd0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_tab_we", 32'(tab_we), 32'(1));
    check("mid_rst_addr", 32'(tab_addr), 32'(0));
    check("mid_rst_ready", 32'(cfg_ready), 32'(0));
    check("mid_rst_rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    init_sweep("reinit");
    do_cmd("after_rst", 2'd1, 10'd12, 4'b0001, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      r_op = 2'd0;
      else if (r == 1) r_op = 2'd3;
      else if (r < 10) r_op = 2'd1;
      else             r_op = 2'd2;
      r_sid = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 0) r_vc = CN'(1) << $urandom_range(0, CN - 1);
      else                           r_vc = CN'($urandom);
      do_cmd("rand", r_op, r_sid, r_vc, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
